// File: rtl/dct_pkg.sv
// Shared constants, block mode encoding and the transpose address helper
// for the row/column DCT datapath.
package dct_pkg;

  localparam int unsigned DCT_N       = 8;
  localparam int unsigned DCT_DW_IN   = 8;
  localparam int unsigned DCT_DW_COEF = 9;

  typedef enum logic {
    XPOSE  = 1'b0,
    BYPASS = 1'b1
  } dct_mode_e;

  // Row-major address of element (c, r) when reading element (r, c) of the transpose.
  function automatic int unsigned xpose_addr(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned n);
    return c * n + r;
  endfunction

endpackage

// File: rtl/dct_xpose_bank.sv
// One N x N sample bank: synchronous write port, asynchronous indexed read.
module dct_xpose_bank #(
  parameter int unsigned DW = 9,
  parameter int unsigned N  = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(N*N)-1:0]     waddr,
  input  logic [DW-1:0]              wdata,
  input  logic [$clog2(N*N)-1:0]     raddr,
  output logic [DW-1:0]              rdata
);

  logic [DW-1:0] mem [N*N];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dct_xpose_buf.sv
// Ping-pong N x N transpose buffer with valid/ready streams, per-block bypass
// and block framing. Optional stall counter port under DCT_XPOSE_STALL_CNT_EN.
module dct_xpose_buf
  import dct_pkg::*;
#(
  parameter int unsigned DW = DCT_DW_COEF,
  parameter int unsigned N  = DCT_N
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_bypass,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sob,
  output logic          out_eob
`ifdef DCT_XPOSE_STALL_CNT_EN
  , output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned AW   = $clog2(N*N);
  localparam int unsigned LW   = $clog2(N);
  localparam int unsigned LAST = N*N - 1;

  logic [1:0]    full_q, full_d;
  dct_mode_e     mode_q [2];
  dct_mode_e     mode_d [2];
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] bank_rdata [2];
  logic          wr_fire, rd_fire;

  // Handshake flags come only from registered state.
  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_xpose_bank #(.DW(DW), .N(N)) u_bank (
      .clk   (CLK),
      .we    (wr_fire && (wr_bank_q == 1'(b))),
      .waddr (wr_cnt_q),
      .wdata (in_data),
      .raddr (rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  // Pointer, counter and flag updates; read address targets the next head sample.
  always_comb begin
    full_d    = full_q;
    mode_d    = mode_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    rd_addr   = '0;

    if (wr_fire) begin
      if (wr_cnt_q == '0) begin
        mode_d[wr_bank_q] = in_bypass ? BYPASS : XPOSE;
      end
      if (wr_cnt_q == AW'(LAST)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_cnt_d          = '0;
        wr_bank_d         = !wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end

    if (rd_fire) begin
      if (rd_cnt_q == AW'(LAST)) begin
        full_d[rd_bank_q] = 1'b0;
        rd_cnt_d          = '0;
        rd_bank_d         = !rd_bank_q;
      end else begin
        rd_cnt_d = rd_cnt_q + AW'(1);
      end
    end

    // A head whose bank is still filling is reloaded every cycle until it turns full.
    if (mode_q[rd_bank_d] == BYPASS) begin
      rd_addr = rd_cnt_d;
    end else begin
      rd_addr = AW'(xpose_addr(32'(rd_cnt_d[AW-1:LW]), 32'(rd_cnt_d[LW-1:0]), N));
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      full_q    <= '0;
      mode_q[0] <= XPOSE;
      mode_q[1] <= XPOSE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      full_q    <= full_d;
      mode_q    <= mode_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Output sample and framing hold naturally under backpressure since the pointers hold.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_data <= '0;
      out_sob  <= 1'b0;
      out_eob  <= 1'b0;
    end else begin
      out_data <= rd_bank_d ? bank_rdata[1] : bank_rdata[0];
      out_sob  <= (rd_cnt_d == '0);
      out_eob  <= (rd_cnt_d == AW'(LAST));
    end
  end

`ifdef DCT_XPOSE_STALL_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dct_xpose_buf.md
Name: dct_xpose_buf

Overview:
- Parametrised ping-pong transpose buffer for the row/column 2-D DCT/IDCT datapath.
- Sits between the 1-D row stage and the 1-D column stage, and between dct and idct in loopback tops.
- Replaces the fixed 8x8, single rdy-strobe coupling with an N x N, DW-wide valid/ready stream.
- Adds a per-block bypass mode and block framing.

Parameters:
- DW, 9, sample width in bits (matches dct_2d).
- N, 8, block dimension (N x N samples per block, N a power of 2, 2..16).
- AW, $clog2(N*N), element index width (derived, not to be overridden).

Ports:
- CLK  in  1  clock, all logic on the rising edge.
- RST  in  1  asynchronous active-low reset.
- in_data  in  DW  input sample, row-major order.
- in_valid  in  1  input sample valid.
- in_ready  out  1  buffer can accept a sample.
- in_bypass  in  1  mode for the block being written: 0 = transpose, 1 = pass-through (row-major out).
- out_data  out  DW  output sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_sob  out  1  first sample of an output block (qualified by out_valid).
- out_eob  out  1  last sample of an output block (qualified by out_valid).

Behaviour:
- Reset (RST low, asynchronous) values:
  - Both banks empty; wr_bank = rd_bank = 0; counters = 0.
  - in_ready = 1; out_valid = 0; out_data = 0; out_sob = out_eob = 0.
  - Memory contents are don't-care.
- Storage: two banks of N*N x DW registers.
- Per-bank state: full flag and a latched bypass bit.
- Write side:
  - A beat transfers when in_valid && in_ready.
  - The sample is stored at wr_cnt in bank wr_bank; wr_cnt increments.
  - in_bypass is latched into the bank's mode bit on the beat with wr_cnt == 0 and ignored on later beats of that block.
  - On the beat with wr_cnt == N*N-1: bank marked full, wr_cnt wraps to 0, wr_bank toggles.
  - in_ready = !full[wr_bank]; it is combinational from registered flags only, with no path from in_valid.
- Read side:
  - out_valid = full[rd_bank].
  - Index r = rd_cnt / N, c = rd_cnt % N.
  - Transpose mode reads address c*N + r; bypass mode reads rd_cnt.
  - out_data, out_sob (rd_cnt == 0) and out_eob (rd_cnt == N*N-1) are registered, so they are stable while out_valid && !out_ready.
  - A beat transfers when out_valid && out_ready; rd_cnt increments.
  - On the eob beat: full[rd_bank] cleared, rd_cnt wraps, rd_bank toggles.
- Latency: first output valid exactly 1 cycle after the cycle the last input of the block is accepted.
- Throughput: 1 sample/cycle sustained with both sides always ready; a block is read while the next is written.
- Simultaneous events:
  - Writer filling bank X and reader releasing bank Y in the same cycle are both applied.
  - Clearing and setting the same bank cannot coincide: the writer never owns a full bank.
- Both banks full: in_ready = 0 until the next eob beat; in_ready rises the cycle after that beat.
- Backpressure: out_data, out_sob and out_eob hold, and rd_cnt holds, while out_ready = 0.
- Input bubbles: in_valid low mid-block leaves wr_cnt unchanged; there is no timeout.
- Reset mid-block: partial blocks are discarded and everything returns to reset values; there is no partial output.
- No arithmetic on data: samples pass bit-exact, with no sign or width change.

Optional Feature:
- Macro: DCT_XPOSE_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (16 bits).
  - Counts cycles with in_valid && !in_ready; saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: the port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package dct_pkg holds:
  - DCT_N = 8, DCT_DW_IN = 8, DCT_DW_COEF = 9.
  - Typedef dct_mode_e {XPOSE = 0, BYPASS = 1}.
  - Function for the transpose address (r, c, N).
- One sub-module, dct_xpose_bank: a single N*N register bank with write port and async-index read. It is instantiated twice; the top holds the pointers, counters and flags.

Test Plan:
- Reset then stream samples 0..63 (N=8, in_bypass=0, out_ready=1):
  - Outputs follow the order 0,8,16,..,56,1,9,..,63.
  - out_sob on the first output, out_eob on the 64th.
  - First out_valid 1 cycle after the 64th input.
- Same stream with in_bypass=1 -> output 0..63 in order.
- Also toggle in_bypass at sample 5 -> the mode latched at sample 0 holds for the whole block.
- Three back-to-back blocks with out_ready=0 -> in_ready drops after the 128th sample and stays low.
  - Release out_ready -> in_ready rises 1 cycle after the first eob beat.
  - Block 3 is intact.
- Random out_ready (50%) and in_valid (70%) over 20 blocks, DW=12, N=4 -> scoreboard matches the transposed data.
  - out_data is stable whenever out_valid && !out_ready.
- Assert RST low after 30 samples of a block -> in_ready=1 and out_valid=0 immediately.
  - The next full block outputs correctly with no stale samples.
- With DCT_XPOSE_STALL_CNT_EN: hold out_ready=0, fill both banks, then hold in_valid=1 for 10 cycles -> stall_cnt = 10.
  - Without the macro the build has no stall_cnt port.
